// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding, BCD digit type and saturation helper for the BCD countdown timer.
package countdown_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} cd_state_t;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    function automatic bcd_digit_t bcd_sat(input bcd_digit_t digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD digit register with saturating load and borrow-driven decrement.
module bcd_digit_down
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       borrow_in,
    input  bcd_digit_t load_val,
    output bcd_digit_t digit,
    output bcd_digit_t digit_next,
    output logic       borrow_out,
    output logic       zero
);
    assign zero       = digit == 4'd0;
    assign borrow_out = zero & borrow_in;
    always_comb digit_next = load ? bcd_sat(load_val) : borrow_in ? (zero ? BCD_MAX : digit - 4'd1) : digit;
    always_ff @(posedge clk or posedge reset)
        if (reset) digit <= '0;
        else       digit <= digit_next;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: DIGITS-digit BCD down-counter with run/pause/expire control.
// Optional COUNTDOWN_WARN_EN adds WARN_LEVEL and a registered low-time warn output.
module bcd_countdown_timer
    import countdown_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b0
`ifdef COUNTDOWN_WARN_EN
    ,
    parameter logic [4*DIGITS-1:0] WARN_LEVEL = 'h10
`endif
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    input  logic                loadN,
    input  logic [4*DIGITS-1:0] datain,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                done,
    output logic                busy
`ifdef COUNTDOWN_WARN_EN
    ,
    output logic                warn
`endif
);
    localparam int W = 4*DIGITS;
    cd_state_t state, state_next;
    logic [W-1:0] count_next;
    logic [DIGITS:0] borrow;
    logic [DIGITS-1:0] zero;
    logic dec, hit_zero, done_next, busy_next;

    assign dec       = (state == RUN) & tick & loadN & ~stop;
    assign borrow[0] = dec;
    // a borrow rippling out of the top digit is the zero-to-nines wrap, never a zero arrival
    assign hit_zero  = dec & ~borrow[DIGITS] & ~|count_next;
    assign tc        = &zero;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (~loadN),
            .borrow_in  (borrow[i]),
            .load_val   (datain[4*i +: 4]),
            .digit      (count[4*i +: 4]),
            .digit_next (count_next[4*i +: 4]),
            .borrow_out (borrow[i+1]),
            .zero       (zero[i])
        );
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            busy  <= busy_next;
        end

    always_comb begin
        state_next = state;
        if (!loadN)
            state_next = IDLE;
        else if (stop)
            state_next = (state == RUN) ? PAUSE : state;
        else if (start && ((state == IDLE && !tc) || state == PAUSE))
            state_next = RUN;
        else if (hit_zero && !WRAP)
            state_next = EXPIRED;
    end

    always_comb begin
        done_next = hit_zero;
        busy_next = state_next == RUN;
    end

`ifdef COUNTDOWN_WARN_EN
    // BCD packing preserves numeric order, so a plain unsigned compare is valid
    always_ff @(posedge clk or posedge reset)
        if (reset) warn <= 1'b0;
        else       warn <= (state_next == RUN || state_next == PAUSE) && |count_next && count_next <= WARN_LEVEL;
`endif
endmodule
